// File: rtl/dfc_sender_arb.sv
// Round-robin, packet-locking arbiter driving a registered vld/data/eop DFC link.
// Every send decision uses fc_q, the registered copy of the receiver's fc_n.
module dfc_sender_arb #(
   parameter int  width  = 8,
   parameter int  inputs = 4,
   localparam int isz    = $clog2(inputs)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [inputs-1:0]       r_srdy,
   output logic [inputs-1:0]       r_drdy,
   input  logic [inputs*width-1:0] r_data,
   input  logic [inputs-1:0]       r_eop,
   output logic                    p_vld,
   output logic [width-1:0]        p_data,
   output logic                    p_eop,
   input  logic                    p_fc_n,
   output logic [isz-1:0]          p_grant,
   output logic                    p_locked
);
   typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

   state_t           state;
   logic             fc_q;
   logic [isz-1:0]   rr;
   logic [isz-1:0]   sel;
   logic [isz-1:0]   sel_next;
   logic             found;
   logic             xfer;
   logic             sel_eop;
   logic [width-1:0] sel_data;

   // Grant is combinational so a requester is accepted in the cycle it asks.
   always_comb begin
      sel    = p_grant;
      found  = 1'b0;
      r_drdy = '0;
      if (state == LOCK) begin
         r_drdy[p_grant] = fc_q;
      end else begin
         for (int k = 0; k < inputs; k++) begin
            if (!found && r_srdy[(int'(rr) + k) % inputs]) begin
               found = 1'b1;
               sel   = isz'((int'(rr) + k) % inputs);
            end
         end
         if (found) r_drdy[sel] = fc_q;
      end
   end

   assign xfer     = |(r_srdy & r_drdy);
   assign sel_eop  = r_eop[sel];
   assign sel_data = r_data[int'(sel)*width +: width];
   assign sel_next = (sel == isz'(inputs - 1)) ? '0 : sel + isz'(1);
   assign p_locked = (state == LOCK);

   always_ff @(posedge clk) begin
      if (reset) begin
         fc_q    <= 1'b0;
         state   <= IDLE;
         rr      <= '0;
         p_grant <= '0;
         p_vld   <= 1'b0;
         p_eop   <= 1'b0;
      end else begin
         fc_q  <= p_fc_n;
         p_vld <= xfer;
         if (xfer) p_eop <= sel_eop;
         case (state)
            IDLE: begin
               if (xfer) begin
                  if (sel_eop) begin
                     rr <= sel_next;
                  end else begin
                     state   <= LOCK;
                     p_grant <= sel;
                  end
               end
            end
            LOCK: begin
               if (xfer && sel_eop) begin
                  state <= IDLE;
                  rr    <= sel_next;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Link data carries no reset; p_vld qualifies it.
   always_ff @(posedge clk) begin
      if (xfer) p_data <= sel_data;
   end
endmodule
